// File: rtl/inst_axi_bridge_pkg.sv
// Shared definitions for the instruction-side SRAM-to-AXI bridge.
//   BRIDGE_ID_W     : width of the AXI read ID
//   AXI_BURST_INCR  : arburst encoding for INCR
//   AXI_SIZE_4B     : arsize encoding for a 4-byte beat
//   AXI_LEN_1BEAT   : arlen for a single-beat burst
//   ar_state_t      : AR channel state (idle / address presented)
//   ctr_width()     : bits needed to count 0..max_out inclusive
package inst_axi_bridge_pkg;

  localparam int         BRIDGE_ID_W    = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  function automatic int ctr_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Bus bundles used by the instruction bridge.
//   inst_sram_if : fetch-stage SRAM-like port.
//                  master = fetch stage (drives req/addr), slave = bridge.
//                  req, wr, size[1:0], addr[31:0], wstrb[3:0], wdata[31:0]
//                  addrok, dataok, rdata[31:0]
//   axi_rd_if    : single-beat AXI read channels (AR + R).
//                  master = bridge, slave = memory / interconnect.
//                  arid, araddr, arlen, arsize, arburst, arvalid, arready
//                  rid, rdata, rresp, rlast, rvalid, rready
interface inst_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addrok;
  logic        dataok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wstrb, wdata,
                  input  addrok, dataok, rdata);
  modport slave  (input  req, wr, size, addr, wstrb, wdata,
                  output addrok, dataok, rdata);
endinterface

interface axi_rd_if;
  import inst_axi_bridge_pkg::*;
  logic [BRIDGE_ID_W-1:0] arid;
  logic [31:0]            araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [BRIDGE_ID_W-1:0] rid;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  input  arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/inst_axi_bridge_outstanding_ctr.sv
// outstanding_ctr: in-flight transaction counter with limit compare.
// Shared with the data-side bridge.
//   clk, reset : clock, synchronous active-high reset
//   inc        : a transaction was accepted this cycle
//   dec        : a transaction retired this cycle
//   cnt        : current in-flight count
//   cnt_next   : count after this cycle's inc/dec
//   below_max  : cnt < MAX, i.e. room for another accept
module outstanding_ctr
  import inst_axi_bridge_pkg::*;
#(
  parameter  int MAX = 2,
  localparam int CW  = ctr_width(MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          below_max
);

  // inc and dec together cancel out
  always_comb begin
    cnt_next = cnt;
    case ({inc, dec})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

  assign below_max = (cnt < CW'(MAX));

endmodule

// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: fetch-stage SRAM-like port -> single-beat AXI read.
// Tracks up to MAX_OUTSTANDING accepted-but-undelivered fetches; every
// returned word is registered and presented with a one-cycle dataok.
// Optional feature macro INST_BRIDGE_CANCEL_EN adds a flush input that
// discards the responses of every fetch in flight at the flush.
//   clk, reset : clock, synchronous active-high reset
//   flush      : exception flush pulse (only with INST_BRIDGE_CANCEL_EN)
//   sram       : inst_sram_if.slave (req/addr in, addrok/dataok/rdata out;
//                wr/size/wstrb/wdata ignored)
//   axi        : axi_rd_if.master (AR + R; rid/rresp/rlast ignored)
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter int                     MAX_OUTSTANDING = 2,
  parameter logic [BRIDGE_ID_W-1:0] ARID_VAL        = '0
) (
  input  logic      clk,
  input  logic      reset,
`ifdef INST_BRIDGE_CANCEL_EN
  input  logic      flush,
`endif
  inst_sram_if.slave sram,
  axi_rd_if.master   axi
);

  localparam int CW = ctr_width(MAX_OUTSTANDING);

  ar_state_t   ar_state, ar_state_nxt;
  logic        addrok, accept, below_max, drop;
  logic [31:0] araddr_q;
  logic [31:0] rbuf;
  logic        rbuf_v;
  logic [CW-1:0] cnt, cnt_next;

  // Only one AR may be presented at a time; the limit gate keeps cnt
  // from overflowing.
  assign addrok = (ar_state == AR_IDLE) && below_max;
  assign accept = sram.req && addrok;

  // ---------------- AR channel ----------------
  always_ff @(posedge clk) begin
    if (reset) ar_state <= AR_IDLE;
    else       ar_state <= ar_state_nxt;
  end

  always_comb begin
    ar_state_nxt = ar_state;
    case (ar_state)
      AR_IDLE: if (accept)      ar_state_nxt = AR_BUSY;
      AR_BUSY: if (axi.arready) ar_state_nxt = AR_IDLE;
      default:                  ar_state_nxt = AR_IDLE;
    endcase
  end

  // Address only loads on accept, which cannot happen while arvalid is
  // high, so it is stable for the whole AR handshake.
  always_ff @(posedge clk) begin
    if (reset)       araddr_q <= '0;
    else if (accept) araddr_q <= sram.addr;
  end

  // ---------------- R channel ----------------
  // No backpressure: every beat is captured and shown for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf   <= '0;
      rbuf_v <= 1'b0;
    end else begin
      rbuf_v <= axi.rvalid;
      if (axi.rvalid) rbuf <= axi.rdata;
    end
  end

  // Retire on the delivery cycle (one after the R beat), so addrok
  // reopens the cycle after dataok.
  outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .inc       (accept),
    .dec       (rbuf_v),
    .cnt       (cnt),
    .cnt_next  (cnt_next),
    .below_max (below_max)
  );

  // ---------------- flush cancel ----------------
`ifdef INST_BRIDGE_CANCEL_EN
  // Everything still owed after this cycle (including a same-cycle
  // accept, excluding a same-cycle delivery) must be thrown away.
  // Responses return in order, so the next drop_cnt beats are exactly
  // those. A second flush simply reloads.
  logic [CW-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset)               drop_cnt <= '0;
    else if (flush)          drop_cnt <= cnt_next;
    else if (rbuf_v && drop) drop_cnt <= drop_cnt - CW'(1);
  end

  assign drop = (drop_cnt != '0);
`else
  assign drop = 1'b0;

  logic unused_cnt_next;
  assign unused_cnt_next = ^cnt_next;
`endif

  // ---------------- outputs ----------------
  assign sram.addrok = addrok;
  assign sram.dataok = rbuf_v && !drop;
  assign sram.rdata  = rbuf;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = AXI_LEN_1BEAT;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (ar_state == AR_BUSY);
  assign axi.rready  = 1'b1;

  // Fetch is read-only and single-ID/single-beat with no bus-error path.
  logic unused_ok;
  assign unused_ok = ^{sram.wr, sram.size, sram.wstrb, sram.wdata,
                       axi.rid, axi.rresp, axi.rlast, cnt};

endmodule

// File: tb/tb_inst_axi_bridge.sv
module tb_inst_axi_bridge;
  import inst_axi_bridge_pkg::*;

`ifdef INST_BRIDGE_CANCEL_EN
  localparam int MAX = 3;   // flush scenario needs a third slot
`else
  localparam int MAX = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  inst_sram_if sram();
  axi_rd_if    axi();

  inst_axi_bridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(4'h5)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef INST_BRIDGE_CANCEL_EN
    .flush (flush),
`endif
    .sram  (sram),
    .axi   (axi)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // memory contents as seen by the slave
  function automatic logic [31:0] word_for(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h3c1d0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- AXI slave ----------------
  typedef struct { int due; logic [31:0] w; } rsp_t;
  rsp_t        rq[$];
  int          cyc = 0;
  int          r_lat = 0;      // extra R cycles after the AR handshake
  int          ar_stall = 0;   // arvalid cycles with arready held low
  int          ar_wait = 0;
  bit          fire_s, rst_s;
  logic [31:0] fire_addr;

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rid = '0; axi.rresp = '0; axi.rlast = 1'b1;
    forever begin
      @(negedge clk);
      rst_s     = reset;
      fire_s    = !reset && axi.arvalid && axi.arready;
      fire_addr = axi.araddr;
      if (fire_s) ar_wait = 0;
      else if (axi.arvalid) ar_wait++;
      @(posedge clk);
      cyc++;
      #2;
      if (rst_s) begin
        rq.delete();
        ar_wait = 0;
      end else if (fire_s) begin
        rq.push_back('{cyc + r_lat, word_for(fire_addr)});
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        axi.rvalid = 1'b1;
        axi.rdata  = rq[0].w;
        void'(rq.pop_front());
      end else begin
        axi.rvalid = 1'b0;
        axi.rdata  = 32'hdeadbeef;
      end
      axi.arready = (ar_wait >= ar_stall);
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // Tracks fetches as a queue of addresses: accepted -> AR outstanding ->
  // answered (word due next cycle) -> delivered or discarded.
  int          m_inflight, m_drop;
  bit          m_ar_pend, m_resp_due, mdl_on;
  logic [31:0] m_ar_addr, m_resp_word;
  logic [31:0] fq[$];
  int          n_dataok = 0, n_rvalid = 0;

  initial begin
    bit exp_addrok, acc, hs;
    mdl_on = 0;
    forever begin
      @(negedge clk);
      exp_addrok = !m_ar_pend && (m_inflight < MAX);
      if (mdl_on) begin
        chk("m_addrok",  32'(sram.addrok), 32'(exp_addrok));
        chk("m_arvalid", 32'(axi.arvalid), 32'(m_ar_pend));
        chk("m_araddr",  axi.araddr, m_ar_addr);
        chk("m_dataok",  32'(sram.dataok), 32'(m_resp_due && m_drop == 0));
        chk("m_rdata",   sram.rdata, m_resp_word);
        chk("m_cnt",     32'(dut.u_ctr.cnt), 32'(m_inflight));
        if (sram.dataok) n_dataok++;
        if (axi.rvalid && !reset) n_rvalid++;
      end
      if (reset) begin
        m_inflight = 0; m_drop = 0; m_ar_pend = 0; m_resp_due = 0;
        m_ar_addr = '0; m_resp_word = '0; fq.delete();
        mdl_on = 1;
      end else if (mdl_on) begin
        acc = sram.req && exp_addrok;
        hs  = m_ar_pend && axi.arready;
        m_inflight = m_inflight + int'(acc) - int'(m_resp_due);
        if (flush) m_drop = m_inflight;
        else if (m_resp_due && m_drop > 0) m_drop--;
        if (acc) begin
          m_ar_pend = 1; m_ar_addr = sram.addr; fq.push_back(sram.addr);
        end else if (hs) m_ar_pend = 0;
        m_resp_due = axi.rvalid;
        if (axi.rvalid && fq.size() > 0) m_resp_word = word_for(fq.pop_front());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_dataok(input string nm, input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sram.dataok && n < maxc);
    chk({nm, "_seen"}, 32'(sram.dataok), 32'd1);
  endtask

  logic [31:0] lim_w [3] = '{32'h3c1d0001, 32'h0004fffb, 32'h0008fff7};

  initial begin
    int n, d0, r0;
    reset = 1'b1; flush = 1'b0;
    sram.req = 1'b0; sram.wr = 1'b0; sram.size = 2'd2; sram.addr = '0;
    sram.wstrb = '0; sram.wdata = '0;
    tick(); tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_addrok",  32'(sram.addrok), 32'd1);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_dataok",  32'(sram.dataok), 32'd0);
    chk("rst_araddr",  axi.araddr, 32'd0);
    chk("rst_rdata",   sram.rdata, 32'd0);

    // single fetch: accept T, arvalid T+1, rvalid T+2, dataok T+3
    tick(); sram.req = 1'b1; sram.addr = 32'hbfc00000;
    @(negedge clk); chk("sf_addrok", 32'(sram.addrok), 32'd1);
    tick(); sram.req = 1'b0;
    @(negedge clk);
    chk("sf_arvalid", 32'(axi.arvalid), 32'd1);
    chk("sf_araddr",  axi.araddr, 32'hbfc00000);
    chk("sf_arid",    32'(axi.arid), 32'h5);
    chk("sf_arlen",   32'(axi.arlen), 32'd0);
    chk("sf_arsize",  32'(axi.arsize), 32'd2);
    chk("sf_arburst", 32'(axi.arburst), 32'd1);
    chk("sf_rready",  32'(axi.rready), 32'd1);
    tick();
    @(negedge clk); chk("sf_t2_dataok", 32'(sram.dataok), 32'd0);
    tick();
    @(negedge clk);
    chk("sf_t3_dataok", 32'(sram.dataok), 32'd1);
    chk("sf_t3_rdata",  sram.rdata, 32'h3c1d0001);

    // AR stall: arready low for 4 arvalid cycles, handshake in the 5th
    tick(); ar_stall = 4; sram.req = 1'b1; sram.addr = 32'hbfc00010;
    tick(); sram.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_arvalid", 32'(axi.arvalid), 32'd1);
      chk("st_araddr",  axi.araddr, 32'hbfc00010);
      chk("st_addrok",  32'(sram.addrok), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("st_hs_arvalid", 32'(axi.arvalid), 32'd1);
    chk("st_hs_arready", 32'(axi.arready), 32'd1);
    tick(); ar_stall = 0;
    @(negedge clk); chk("st_after_addrok", 32'(sram.addrok), 32'd1);
    wait_dataok("st", 6);
    chk("st_rdata", sram.rdata, 32'h0010ffef);

    // outstanding limit with long R latency
    tick(); r_lat = 10;
    for (int i = 0; i < MAX; i++) begin
      sram.req = 1'b1; sram.addr = 32'hbfc00000 + 32'(4 * i);
      @(negedge clk); chk("lim_accept", 32'(sram.addrok), 32'd1);
      tick(); sram.req = 1'b0;
      tick();
    end
    @(negedge clk);
    chk("lim_full_addrok", 32'(sram.addrok), 32'd0);
    chk("lim_full_cnt",    32'(dut.u_ctr.cnt), 32'(MAX));
    wait_dataok("lim0", 40);
    chk("lim0_rdata",  sram.rdata, lim_w[0]);
    chk("lim0_addrok", 32'(sram.addrok), 32'd0);
    tick();
    @(negedge clk); chk("lim_reopen_addrok", 32'(sram.addrok), 32'd1);
    for (int i = 1; i < MAX; i++) begin
      wait_dataok("limn", 20);
      chk("limn_rdata", sram.rdata, lim_w[i]);
    end

    // same-cycle accept and delivery leave cnt unchanged
    tick(); r_lat = 1; sram.req = 1'b1; sram.addr = 32'hbfc00020;
    tick(); sram.req = 1'b0;
    tick(); tick();
    tick(); sram.req = 1'b1; sram.addr = 32'hbfc00024;
    @(negedge clk);
    chk("sc_dataok", 32'(sram.dataok), 32'd1);
    chk("sc_rdata",  sram.rdata, 32'h0020ffdf);
    chk("sc_addrok", 32'(sram.addrok), 32'd1);
    chk("sc_cnt_before", 32'(dut.u_ctr.cnt), 32'd1);
    tick(); sram.req = 1'b0;
    @(negedge clk);
    chk("sc_cnt_after", 32'(dut.u_ctr.cnt), 32'd1);
    chk("sc_araddr",    axi.araddr, 32'hbfc00024);
    wait_dataok("sc2", 8);
    chk("sc2_rdata", sram.rdata, 32'h0024ffdb);

    // reset with cnt=2 and an AR held valid
    tick(); r_lat = 20; sram.req = 1'b1; sram.addr = 32'hbfc00030;
    tick(); sram.req = 1'b0;
    tick(); ar_stall = 50; sram.req = 1'b1; sram.addr = 32'hbfc00034;
    tick(); sram.req = 1'b0;
    @(negedge clk);
    chk("rm_pre_arvalid", 32'(axi.arvalid), 32'd1);
    chk("rm_pre_cnt",     32'(dut.u_ctr.cnt), 32'd2);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; ar_stall = 0;
    @(negedge clk);
    chk("rm_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rm_dataok",  32'(sram.dataok), 32'd0);
    chk("rm_addrok",  32'(sram.addrok), 32'd1);
    chk("rm_araddr",  axi.araddr, 32'd0);
    chk("rm_rdata",   sram.rdata, 32'd0);

`ifdef INST_BRIDGE_CANCEL_EN
    // flush with a third fetch accepted in the same cycle
    tick(); r_lat = 8; d0 = n_dataok; r0 = n_rvalid;
    sram.req = 1'b1; sram.addr = 32'hbfc00200;
    tick(); sram.req = 1'b0;
    tick(); sram.req = 1'b1; sram.addr = 32'hbfc00204;
    tick(); sram.req = 1'b0;
    tick(); sram.req = 1'b1; sram.addr = 32'hbfc00208; flush = 1'b1;
    @(negedge clk); chk("fl_accept", 32'(sram.addrok), 32'd1);
    tick(); sram.req = 1'b0; flush = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (dut.u_ctr.cnt != 0 && n < 60);
    chk("fl_drained_cnt", 32'(dut.u_ctr.cnt), 32'd0);
    chk("fl_no_dataok",   32'(n_dataok - d0), 32'd0);
    chk("fl_responses",   32'(n_rvalid - r0), 32'd3);
    tick(); r_lat = 0; sram.req = 1'b1; sram.addr = 32'hbfc00380;
    tick(); sram.req = 1'b0;
    wait_dataok("fl_new", 8);
    chk("fl_new_rdata", sram.rdata, 32'h0380fc7f);
`else
    n = 0; d0 = 0; r0 = 0;
`endif

    tick(); tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
